// File: rtl/ecdsa_cls_upd_queue_pkg.sv
// Shared types and widths for the ecdsa -> classifier update queue.
package ecdsa_cls_upd_queue_pkg;

   localparam int unsigned REAL_TIME_NBITS  = 32;
   localparam int unsigned EXP_TIME_NBITS   = 16;
   localparam int unsigned FID_NBITS        = 12;
   localparam int unsigned TID_NBITS        = 8;
   localparam int unsigned CLS_UPD_ID_NBITS = (FID_NBITS > TID_NBITS) ? FID_NBITS : TID_NBITS;

   typedef enum logic {CLS_UPD_FLOW = 1'b0, CLS_UPD_TOPIC = 1'b1} cls_upd_type_e;

   typedef struct packed {
      cls_upd_type_e               upd_type;
      logic [CLS_UPD_ID_NBITS-1:0] id;
      logic [EXP_TIME_NBITS-1:0]   etime;
   } cls_upd_t;

   typedef enum logic {StIdle, StHold} out_state_e;

   // Wrap-aware: an entry expiring exactly now counts as expired.
   function automatic logic etime_expired(input logic [EXP_TIME_NBITS-1:0] etime,
                                          input logic [EXP_TIME_NBITS-1:0] now);
      logic [EXP_TIME_NBITS-1:0] diff;
      diff = etime - now;
      return ($signed(diff) <= 0);
   endfunction

endpackage

// File: rtl/ecdsa_upd_fifo.sv
// Synchronous FIFO with combinational head and full/empty flags.
module ecdsa_upd_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AddrW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
   logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
   logic             push_ok, pop_ok;

   assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign head_o  = mem_q[rd_ptr_q[AddrW-1:0]];

   // Full is judged on the registered pointers, so a same-cycle pop does not admit a push.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
   end

endmodule

// File: rtl/ecdsa_cls_upd_queue.sv
// Queues flow/topic expiry updates from ecdsa and feeds them round-robin to the
// classifier write port, dropping already-expired entries.
module ecdsa_cls_upd_queue
   import ecdsa_cls_upd_queue_pkg::*;
#(
   parameter int unsigned FLOW_Q_DEPTH  = 8,
   parameter int unsigned TOPIC_Q_DEPTH = 8,
   parameter int unsigned CNT_NBITS     = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [REAL_TIME_NBITS-1:0]  current_time_i,
   input  logic                        ecdsa_classifier_flow_valid_i,
   input  logic [FID_NBITS-1:0]        ecdsa_classifier_fid_i,
   input  logic [EXP_TIME_NBITS-1:0]   ecdsa_classifier_flow_etime_i,
   input  logic                        ecdsa_classifier_topic_valid_i,
   input  logic [TID_NBITS-1:0]        ecdsa_classifier_tid_i,
   input  logic [EXP_TIME_NBITS-1:0]   ecdsa_classifier_topic_etime_i,
   output logic                        cls_upd_valid_o,
   output logic                        cls_upd_type_o,
   output logic [CLS_UPD_ID_NBITS-1:0] cls_upd_id_o,
   output logic [EXP_TIME_NBITS-1:0]   cls_upd_etime_o,
   input  logic                        cls_upd_ready_i,
   output logic [CNT_NBITS-1:0]        upd_ovf_cnt_o,
   output logic [CNT_NBITS-1:0]        upd_exp_cnt_o,
   output logic                        upd_ovf_sticky_o
);

   localparam int unsigned UpdW = $bits(cls_upd_t);

   cls_upd_t   flow_entry, topic_entry, flow_head, topic_head, sel_head;
   logic       flow_full, flow_empty, topic_full, topic_empty;
   logic       flow_pop, topic_pop, sel_topic, exp_hit;
   out_state_e state_q, state_d;
   cls_upd_t   out_q, out_d;
   logic       rr_q, rr_d;
   logic [CNT_NBITS-1:0] ovf_cnt_q, ovf_cnt_d, exp_cnt_q, exp_cnt_d;
   logic                 sticky_q, sticky_d;
   logic [1:0]           ovf_inc;
   logic [CNT_NBITS:0]   ovf_sum, exp_sum;
   logic [EXP_TIME_NBITS-1:0] now;
   logic                      unused_time_hi;

   assign now            = current_time_i[EXP_TIME_NBITS-1:0];
   assign unused_time_hi = ^current_time_i[REAL_TIME_NBITS-1:EXP_TIME_NBITS];

   always_comb begin
      flow_entry          = '0;
      flow_entry.upd_type = CLS_UPD_FLOW;
      flow_entry.id       = CLS_UPD_ID_NBITS'(ecdsa_classifier_fid_i);
      flow_entry.etime    = ecdsa_classifier_flow_etime_i;
      topic_entry          = '0;
      topic_entry.upd_type = CLS_UPD_TOPIC;
      topic_entry.id       = CLS_UPD_ID_NBITS'(ecdsa_classifier_tid_i);
      topic_entry.etime    = ecdsa_classifier_topic_etime_i;
   end

   ecdsa_upd_fifo #(
      .Width (UpdW),
      .Depth (FLOW_Q_DEPTH)
   ) u_flow_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (ecdsa_classifier_flow_valid_i),
      .data_i  (flow_entry),
      .pop_i   (flow_pop),
      .head_o  (flow_head),
      .full_o  (flow_full),
      .empty_o (flow_empty)
   );

   ecdsa_upd_fifo #(
      .Width (UpdW),
      .Depth (TOPIC_Q_DEPTH)
   ) u_topic_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (ecdsa_classifier_topic_valid_i),
      .data_i  (topic_entry),
      .pop_i   (topic_pop),
      .head_o  (topic_head),
      .full_o  (topic_full),
      .empty_o (topic_empty)
   );

   // rr_q: 0 favours flow, 1 favours topic.
   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      rr_d      = rr_q;
      flow_pop  = 1'b0;
      topic_pop = 1'b0;
      exp_hit   = 1'b0;
      sel_topic = 1'b0;
      sel_head  = flow_head;
      if (state_q == StIdle || cls_upd_ready_i) begin
         state_d = StIdle;
         if (!flow_empty || !topic_empty) begin
            sel_topic = flow_empty ? 1'b1 : (topic_empty ? 1'b0 : rr_q);
            sel_head  = sel_topic ? topic_head : flow_head;
            flow_pop  = !sel_topic;
            topic_pop = sel_topic;
            if (sel_topic == rr_q) rr_d = ~rr_q;
            if (etime_expired(sel_head.etime, now)) begin
               exp_hit = 1'b1;
            end else begin
               out_d   = sel_head;
               state_d = StHold;
            end
         end
      end
   end

   always_comb begin
      ovf_inc   = {1'b0, ecdsa_classifier_flow_valid_i & flow_full} +
                  {1'b0, ecdsa_classifier_topic_valid_i & topic_full};
      ovf_sum   = {1'b0, ovf_cnt_q} + {{(CNT_NBITS-1){1'b0}}, ovf_inc};
      exp_sum   = {1'b0, exp_cnt_q} + {{CNT_NBITS{1'b0}}, exp_hit};
      ovf_cnt_d = ovf_sum[CNT_NBITS] ? '1 : ovf_sum[CNT_NBITS-1:0];
      exp_cnt_d = exp_sum[CNT_NBITS] ? '1 : exp_sum[CNT_NBITS-1:0];
      sticky_d  = sticky_q | (ovf_inc != 2'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         out_q     <= '0;
         rr_q      <= 1'b0;
         ovf_cnt_q <= '0;
         exp_cnt_q <= '0;
         sticky_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         rr_q      <= rr_d;
         ovf_cnt_q <= ovf_cnt_d;
         exp_cnt_q <= exp_cnt_d;
         sticky_q  <= sticky_d;
      end
   end

   assign cls_upd_valid_o  = (state_q == StHold);
   assign cls_upd_type_o   = out_q.upd_type;
   assign cls_upd_id_o     = out_q.id;
   assign cls_upd_etime_o  = out_q.etime;
   assign upd_ovf_cnt_o    = ovf_cnt_q;
   assign upd_exp_cnt_o    = exp_cnt_q;
   assign upd_ovf_sticky_o = sticky_q;

endmodule

// File: tb/tb_ecdsa_cls_upd_queue.sv
// Scenario bench for ecdsa_cls_upd_queue with an in-order expected-beat scoreboard.
module tb_ecdsa_cls_upd_queue;
   import ecdsa_cls_upd_queue_pkg::*;

   localparam int unsigned CNT_NBITS = 16;

   logic                        clk = 1'b0;
   logic                        rst_n = 1'b0;
   logic [REAL_TIME_NBITS-1:0]  current_time = '0;
   logic                        flow_valid = 1'b0;
   logic [FID_NBITS-1:0]        fid = '0;
   logic [EXP_TIME_NBITS-1:0]   flow_etime = '0;
   logic                        topic_valid = 1'b0;
   logic [TID_NBITS-1:0]        tid = '0;
   logic [EXP_TIME_NBITS-1:0]   topic_etime = '0;
   logic                        upd_valid;
   logic                        upd_type;
   logic [CLS_UPD_ID_NBITS-1:0] upd_id;
   logic [EXP_TIME_NBITS-1:0]   upd_etime;
   logic                        upd_ready = 1'b0;
   logic [CNT_NBITS-1:0]        ovf_cnt, exp_cnt;
   logic                        ovf_sticky;

   int n_cmp  = 0;
   int n_fail = 0;
   int beats  = 0;
   cls_upd_t exp_q[$];

   always #5 clk = ~clk;

   ecdsa_cls_upd_queue #(
      .FLOW_Q_DEPTH  (8),
      .TOPIC_Q_DEPTH (8),
      .CNT_NBITS     (CNT_NBITS)
   ) dut (
      .clk                            (clk),
      .rst_n                          (rst_n),
      .current_time_i                 (current_time),
      .ecdsa_classifier_flow_valid_i  (flow_valid),
      .ecdsa_classifier_fid_i         (fid),
      .ecdsa_classifier_flow_etime_i  (flow_etime),
      .ecdsa_classifier_topic_valid_i (topic_valid),
      .ecdsa_classifier_tid_i         (tid),
      .ecdsa_classifier_topic_etime_i (topic_etime),
      .cls_upd_valid_o                (upd_valid),
      .cls_upd_type_o                 (upd_type),
      .cls_upd_id_o                   (upd_id),
      .cls_upd_etime_o                (upd_etime),
      .cls_upd_ready_i                (upd_ready),
      .upd_ovf_cnt_o                  (ovf_cnt),
      .upd_exp_cnt_o                  (exp_cnt),
      .upd_ovf_sticky_o               (ovf_sticky)
   );

   function automatic cls_upd_t mk(input logic t, input int id, input int et);
      cls_upd_t e;
      e.upd_type = cls_upd_type_e'(t);
      e.id       = CLS_UPD_ID_NBITS'(id);
      e.etime    = EXP_TIME_NBITS'(et);
      return e;
   endfunction

   // Every accepted beat must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && upd_valid && upd_ready) begin
         cls_upd_t obs, e;
         obs.upd_type = cls_upd_type_e'(upd_type);
         obs.id       = upd_id;
         obs.etime    = upd_etime;
         beats++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: got type=%0d id=%0d etime=%0h, expected none",
                     upd_type, upd_id, upd_etime);
         end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
               n_fail++;
               $display("FAIL beat_data: got type=%0d id=%0d etime=%0h, expected type=%0d id=%0d etime=%0h",
                        upd_type, upd_id, upd_etime, e.upd_type, e.id, e.etime);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      flow_valid = 1'b0;
      topic_valid = 1'b0;
      upd_ready = 1'b1;
      current_time = 32'd100;
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_cmp++;
      if ({upd_valid, upd_type, upd_id, upd_etime} !== '0) begin
         n_fail++;
         $display("FAIL reset_out: got valid=%0d type=%0d id=%0d etime=%0h, expected all 0",
                  upd_valid, upd_type, upd_id, upd_etime);
      end
      n_cmp++;
      if (ovf_cnt !== '0 || exp_cnt !== '0 || ovf_sticky !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cnt: got ovf=%0d exp=%0d sticky=%0d, expected 0/0/0",
                  ovf_cnt, exp_cnt, ovf_sticky);
      end
      do_reset();
   endtask

   task automatic test_single();
      int b0;
      do_reset();
      b0 = beats;
      flow_valid = 1'b1; fid = 12'd5; flow_etime = 16'd200;
      exp_q.push_back(mk(1'b0, 5, 200));
      tick();
      flow_valid = 1'b0;
      n_cmp++;
      if (upd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_early: got valid=%0d, expected 0", upd_valid);
      end
      tick();
      n_cmp++;
      if (upd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL single_latency: got valid=%0d, expected 1", upd_valid);
      end
      repeat (4) tick();
      n_cmp++;
      if (beats - b0 != 1 || ovf_cnt !== '0 || exp_cnt !== '0) begin
         n_fail++;
         $display("FAIL single_count: got beats=%0d ovf=%0d exp=%0d, expected 1/0/0",
                  beats - b0, ovf_cnt, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int b0;
      do_reset();
      b0 = beats;
      for (int i = 0; i < 4; i++) begin
         flow_valid = 1'b1; fid = 12'd3; flow_etime = 16'd200;
         topic_valid = 1'b1; tid = 8'd7; topic_etime = 16'd200;
         exp_q.push_back(mk(1'b0, 3, 200));
         exp_q.push_back(mk(1'b1, 7, 200));
         tick();
      end
      flow_valid = 1'b0;
      topic_valid = 1'b0;
      repeat (5) tick();
      #6;
      n_cmp++;
      if (beats - b0 != 8) begin
         n_fail++;
         $display("FAIL b2b_throughput: got %0d beats in 8 cycles, expected 8", beats - b0);
      end
      tick();
      n_cmp++;
      if (upd_valid !== 1'b0 || ovf_cnt !== '0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_drain: got valid=%0d ovf=%0d pending=%0d, expected 0/0/0",
                  upd_valid, ovf_cnt, exp_q.size());
      end
   endtask

   task automatic test_overflow();
      int b0;
      do_reset();
      upd_ready = 1'b0;
      b0 = beats;
      for (int i = 0; i < 10; i++) begin
         flow_valid = 1'b1; fid = FID_NBITS'(i + 1); flow_etime = 16'd200;
         if (i < 9) exp_q.push_back(mk(1'b0, i + 1, 200));
         tick();
      end
      flow_valid = 1'b0;
      n_cmp++;
      if (ovf_cnt !== 16'd1 || ovf_sticky !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_count: got ovf=%0d sticky=%0d, expected 1/1", ovf_cnt, ovf_sticky);
      end
      tick();
      n_cmp++;
      if (upd_valid !== 1'b1 || upd_id !== 12'd1 || upd_etime !== 16'd200 || beats != b0) begin
         n_fail++;
         $display("FAIL ovf_hold: got valid=%0d id=%0d etime=%0d beats=%0d, expected 1/1/200/0",
                  upd_valid, upd_id, upd_etime, beats - b0);
      end
      upd_ready = 1'b1;
      repeat (12) tick();
      n_cmp++;
      if (beats - b0 != 9 || exp_q.size() != 0 || ovf_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL ovf_drain: got beats=%0d pending=%0d ovf=%0d, expected 9/0/1",
                  beats - b0, exp_q.size(), ovf_cnt);
      end
   endtask

   task automatic test_expiry();
      int b0;
      do_reset();
      b0 = beats;
      flow_valid = 1'b1; fid = 12'd8; flow_etime = 16'd100;
      tick();
      fid = 12'd9; flow_etime = 16'd101;
      exp_q.push_back(mk(1'b0, 9, 101));
      tick();
      flow_valid = 1'b0;
      repeat (4) tick();
      n_cmp++;
      if (exp_cnt !== 16'd1 || beats - b0 != 1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL expiry: got exp=%0d beats=%0d pending=%0d, expected 1/1/0",
                  exp_cnt, beats - b0, exp_q.size());
      end
   endtask

   task automatic test_wrap();
      int b0;
      do_reset();
      current_time = 32'h0003_FFF0;
      b0 = beats;
      topic_valid = 1'b1; tid = 8'd4; topic_etime = 16'h0010;
      exp_q.push_back(mk(1'b1, 4, 16'h0010));
      tick();
      topic_valid = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (beats - b0 != 1 || exp_cnt !== '0) begin
         n_fail++;
         $display("FAIL wrap_live: got beats=%0d exp=%0d, expected 1/0", beats - b0, exp_cnt);
      end
      flow_valid = 1'b1; fid = 12'd6; flow_etime = 16'hFFE0;
      tick();
      flow_valid = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (beats - b0 != 1 || exp_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL wrap_expired: got beats=%0d exp=%0d, expected 1/1", beats - b0, exp_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int b0;
      do_reset();
      upd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         flow_valid = 1'b1; fid = FID_NBITS'(20 + i); flow_etime = 16'd200;
         tick();
      end
      flow_valid = 1'b0;
      n_cmp++;
      if (upd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pre: got valid=%0d, expected 1", upd_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (upd_valid !== 1'b0 || upd_id !== '0) begin
         n_fail++;
         $display("FAIL mid_async: got valid=%0d id=%0d, expected 0/0", upd_valid, upd_id);
      end
      tick();
      rst_n = 1'b1;
      upd_ready = 1'b1;
      b0 = beats;
      repeat (10) tick();
      n_cmp++;
      if (beats != b0 || upd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_stale: got beats=%0d valid=%0d, expected 0/0", beats - b0, upd_valid);
      end
      flow_valid = 1'b1; fid = 12'd30; flow_etime = 16'd200;
      exp_q.push_back(mk(1'b0, 30, 200));
      tick();
      flow_valid = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (beats - b0 != 1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL mid_recover: got beats=%0d pending=%0d, expected 1/0",
                  beats - b0, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_expiry();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
